// File: rtl/hyperbus_arb_pkg.sv
// -----------------------------------------------------------------------------
// hyperbus_arb_pkg
//   Shared definitions for the Hyperbus requester arbiter: FSM state encoding
//   (one-hot, 3 bits) and width helpers used by the arbiter, its interface
//   and the round-robin picker.
// -----------------------------------------------------------------------------
package hyperbus_arb_pkg;

    // One-hot arbiter states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,   // no grant
        ST_GRANT = 3'b010,   // one requester owns the bus
        ST_DRAIN = 3'b100    // released, waiting for the controller to go idle
    } hbus_arb_state_e;

    // Byte-mask width for a given data width
    function automatic int unsigned hbus_mask_bits(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Width of a requester index; at least one bit
    function automatic int unsigned hbus_idx_width(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/hyperbus_arb_if.sv
// -----------------------------------------------------------------------------
// hyperbus_arb_if
//   Bundles the requester-side and controller-side signals of the Hyperbus
//   arbiter. Requester buses are packed; requester i occupies slice i.
//
//   Requester side : req_rrq, req_wrq, req_adr, req_dat, req_mask (to arbiter)
//                    req_ready, req_valid, req_dat_o              (from arbiter)
//   Status         : grant (one-hot), hold_err (watchdog pulse)
//   Controller side: hbus_adr_o, hbus_dat_o, hbus_mask_o, hbus_rrq, hbus_wrq
//                    (from arbiter); hbus_dat_i, hbus_ready, hbus_valid,
//                    hbus_busy (to arbiter)
//
//   modport slave : the arbiter itself
//   modport master: the surrounding environment (clients + controller)
// -----------------------------------------------------------------------------
interface hyperbus_arb_if
    import hyperbus_arb_pkg::*;
#(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned HBUS_ADDR_WIDTH = 32,
    parameter int unsigned HBUS_DATA_WIDTH = 16
);
    localparam int unsigned MB = hbus_mask_bits(HBUS_DATA_WIDTH);

    // requester side
    logic [NREQ-1:0]                 req_rrq;
    logic [NREQ-1:0]                 req_wrq;
    logic [NREQ*HBUS_ADDR_WIDTH-1:0] req_adr;
    logic [NREQ*HBUS_DATA_WIDTH-1:0] req_dat;
    logic [NREQ*MB-1:0]              req_mask;
    logic [NREQ-1:0]                 req_ready;
    logic [NREQ-1:0]                 req_valid;
    logic [HBUS_DATA_WIDTH-1:0]      req_dat_o;

    // status
    logic [NREQ-1:0]                 grant;
    logic [NREQ-1:0]                 hold_err;

    // controller side
    logic [HBUS_ADDR_WIDTH-1:0]      hbus_adr_o;
    logic [HBUS_DATA_WIDTH-1:0]      hbus_dat_o;
    logic [MB-1:0]                   hbus_mask_o;
    logic                            hbus_rrq;
    logic                            hbus_wrq;
    logic [HBUS_DATA_WIDTH-1:0]      hbus_dat_i;
    logic                            hbus_ready;
    logic                            hbus_valid;
    logic                            hbus_busy;

    modport slave (
        input  req_rrq, req_wrq, req_adr, req_dat, req_mask,
        output req_ready, req_valid, req_dat_o,
        output grant, hold_err,
        output hbus_adr_o, hbus_dat_o, hbus_mask_o, hbus_rrq, hbus_wrq,
        input  hbus_dat_i, hbus_ready, hbus_valid, hbus_busy
    );

    modport master (
        output req_rrq, req_wrq, req_adr, req_dat, req_mask,
        input  req_ready, req_valid, req_dat_o,
        input  grant, hold_err,
        input  hbus_adr_o, hbus_dat_o, hbus_mask_o, hbus_rrq, hbus_wrq,
        output hbus_dat_i, hbus_ready, hbus_valid, hbus_busy
    );

endinterface

// File: rtl/hyperbus_rr_pick.sv
// -----------------------------------------------------------------------------
// hyperbus_rr_pick
//   Combinational round-robin picker: selects the first requesting index at
//   or after ptr, wrapping past NREQ-1 back to 0.
//
//   req : request vector, one bit per requester
//   ptr : index with highest priority this round
//   gnt : one-hot winner (zero when no request)
//   idx : binary index of the winner (zero when no request)
//   any : at least one request present
// -----------------------------------------------------------------------------
module hyperbus_rr_pick
    import hyperbus_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = hbus_idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] msk;
    logic              found;

    // Doubling the request vector and masking bits below ptr in the lower
    // copy turns the wrap-around search into a plain lowest-bit-first search:
    // requests at/after ptr come from the lower copy, wrapped ones from the
    // upper copy.
    always_comb begin
        dbl = {req, req};
        msk = '0;
        for (int unsigned i = 0; i < 2*NREQ; i++) begin
            msk[i] = dbl[i] & ((i >= NREQ) || (i >= 32'(ptr)));
        end
    end

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2*NREQ; i++) begin
            if (!found && msk[i]) begin
                found           = 1'b1;
                gnt[i % NREQ]   = 1'b1;
                idx             = IW'(i % NREQ);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/hyperbus_arb.sv
// -----------------------------------------------------------------------------
// hyperbus_arb
//   Round-robin arbiter sharing one Hyperbus native memory interface between
//   NREQ requesters, all in the Hyperbus clock domain. One requester is
//   granted per transaction; its request, address, data and mask are
//   forwarded to the controller and the controller's ready/valid strobes are
//   routed back only to it. A hold watchdog revokes a requester that keeps
//   the bus for HOLD_MAX grant cycles.
//
//   hbus_clk   : sole clock
//   hbus_rst_n : asynchronous reset, active low
//   bus        : hyperbus_arb_if.slave -- requester buses, grant/hold_err
//                status and controller request/response signals
// -----------------------------------------------------------------------------
module hyperbus_arb
    import hyperbus_arb_pkg::*;
#(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned HBUS_ADDR_WIDTH = 32,
    parameter int unsigned HBUS_DATA_WIDTH = 16,
    parameter int unsigned HOLD_MAX        = 1024
) (
    input  logic          hbus_clk,
    input  logic          hbus_rst_n,
    hyperbus_arb_if.slave bus
);

    localparam int unsigned MB = hbus_mask_bits(HBUS_DATA_WIDTH);
    localparam int unsigned IW = hbus_idx_width(NREQ);
    localparam int unsigned HW = $clog2(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NREQ - 1);

    // ---------------------------------------------------------------- state
    hbus_arb_state_e  state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    owner_q;
    logic [NREQ-1:0]  grant_q;
    logic [HW-1:0]    hold_q;

    // ---------------------------------------------------------------- picker
    logic [NREQ-1:0]  req_any;
    logic [NREQ-1:0]  pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    assign req_any = bus.req_rrq | bus.req_wrq;

    hyperbus_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (req_any),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // ---------------------------------------------------------------- owner slice select
    logic                       own_rrq;
    logic                       own_wrq;
    logic [HBUS_ADDR_WIDTH-1:0] own_adr;
    logic [HBUS_DATA_WIDTH-1:0] own_dat;
    logic [MB-1:0]              own_mask;
    logic [NREQ-1:0]            owner_oh;

    always_comb begin
        own_rrq  = 1'b0;
        own_wrq  = 1'b0;
        own_adr  = '0;
        own_dat  = '0;
        own_mask = '0;
        owner_oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                owner_oh[i] = 1'b1;
                own_rrq     = bus.req_rrq[i];
                own_wrq     = bus.req_wrq[i];
                own_adr     = bus.req_adr[i*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH];
                own_dat     = bus.req_dat[i*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
                own_mask    = bus.req_mask[i*MB +: MB];
            end
        end
    end

    // ---------------------------------------------------------------- control
    logic          in_grant;
    logic          routed;
    logic          wd_fire;
    logic          own_release;
    logic [IW-1:0] ptr_next;

    assign in_grant    = (state_q == ST_GRANT);
    assign routed      = (state_q == ST_GRANT) || (state_q == ST_DRAIN);
    // Watchdog fires in the last allowed grant cycle, so the forwarded request
    // drops in the same cycle that hold_err pulses.
    assign wd_fire     = in_grant && (hold_q == HOLD_LAST);
    assign own_release = !(own_rrq || own_wrq);
    assign ptr_next    = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;

    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any && !bus.hbus_busy) begin
                        state_q <= ST_GRANT;
                        grant_q <= pick_gnt;
                        owner_q <= pick_idx;
                        hold_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (own_release || wd_fire) begin
                        state_q <= ST_DRAIN;
                    end
                    if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.hbus_busy) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_next;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- forwarding
    logic fwd_en;

    assign fwd_en = in_grant && !wd_fire;

    assign bus.grant       = grant_q;
    assign bus.hold_err    = wd_fire ? owner_oh : '0;

    // read wins when a requester raises both request bits
    assign bus.hbus_rrq    = fwd_en && own_rrq;
    assign bus.hbus_wrq    = fwd_en && own_wrq && !own_rrq;
    assign bus.hbus_adr_o  = in_grant ? own_adr  : '0;
    assign bus.hbus_dat_o  = in_grant ? own_dat  : '0;
    assign bus.hbus_mask_o = in_grant ? own_mask : '0;

    // strobes keep routing through DRAIN so trailing beats reach the owner
    assign bus.req_ready   = (routed && bus.hbus_ready) ? owner_oh : '0;
    assign bus.req_valid   = (routed && bus.hbus_valid) ? owner_oh : '0;
    assign bus.req_dat_o   = bus.hbus_dat_i;

endmodule

// File: tb/tb_hyperbus_arb.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_arb
//   Directed self-checking bench for hyperbus_arb (NREQ=4, 32-bit address,
//   16-bit data, HOLD_MAX=8). Inputs are driven 1 ns after the rising edge,
//   outputs are sampled 3 ns after it.
// -----------------------------------------------------------------------------
module tb_hyperbus_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 16;
    localparam int unsigned MB   = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [AW-1:0] adr_tab [NREQ] = '{32'h0000_00A0, 32'h0000_00B0, 32'h0000_0100, 32'h0000_00D0};
    logic [DW-1:0] dat_tab [NREQ] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [MB-1:0] msk_tab [NREQ] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int            rr_ord  [5]    = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    hyperbus_arb_if #(
        .NREQ            (NREQ),
        .HBUS_ADDR_WIDTH (AW),
        .HBUS_DATA_WIDTH (DW)
    ) bus ();

    hyperbus_arb #(
        .NREQ            (NREQ),
        .HBUS_ADDR_WIDTH (AW),
        .HBUS_DATA_WIDTH (DW),
        .HOLD_MAX        (8)
    ) dut (
        .hbus_clk   (clk),
        .hbus_rst_n (rst_n),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        int n;
        n = 0;
        g = '0;
        while (g == '0 && n < 20) begin
            nxt();
            settle();
            g = bus.grant;
            n++;
        end
        chk("grant_seen", 64'(g != '0), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        logic [NREQ-1:0] g;
        n = 0;
        g = '1;
        while (g != '0 && n < 20) begin
            nxt();
            settle();
            g = bus.grant;
            n++;
        end
        chk("idle_seen", 64'(g == '0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] prev;
        int e;

        bus.req_rrq    = '0;
        bus.req_wrq    = '0;
        bus.hbus_dat_i = '0;
        bus.hbus_ready = 1'b0;
        bus.hbus_valid = 1'b0;
        bus.hbus_busy  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_adr[i*AW +: AW]  = adr_tab[i];
            bus.req_dat[i*DW +: DW]  = dat_tab[i];
            bus.req_mask[i*MB +: MB] = msk_tab[i];
        end

        // ---------------- reset state
        #3;
        chk("rst_grant",    64'(bus.grant),      64'h0);
        chk("rst_hold_err", 64'(bus.hold_err),   64'h0);
        chk("rst_rrq",      64'(bus.hbus_rrq),   64'h0);
        chk("rst_wrq",      64'(bus.hbus_wrq),   64'h0);
        chk("rst_ready",    64'(bus.req_ready),  64'h0);
        chk("rst_valid",    64'(bus.req_valid),  64'h0);
        chk("rst_adr",      64'(bus.hbus_adr_o), 64'h0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // ---------------- single read from requester 2
        bus.req_rrq = 4'b0100;
        settle();
        chk("rd_idle_grant", 64'(bus.grant), 64'h0);
        nxt();
        settle();
        chk("rd_grant", 64'(bus.grant),      64'h4);
        chk("rd_rrq",   64'(bus.hbus_rrq),   64'h1);
        chk("rd_wrq",   64'(bus.hbus_wrq),   64'h0);
        chk("rd_adr",   64'(bus.hbus_adr_o), 64'h100);
        bus.hbus_valid = 1'b1;
        bus.hbus_dat_i = 16'hBEEF;
        bus.hbus_busy  = 1'b1;
        #1;
        chk("rd_valid1", 64'(bus.req_valid), 64'h4);
        chk("rd_dat1",   64'(bus.req_dat_o), 64'hBEEF);
        chk("rd_ready0", 64'(bus.req_ready), 64'h0);
        nxt();
        bus.hbus_dat_i = 16'hCAFE;
        settle();
        chk("rd_valid2", 64'(bus.req_valid), 64'h4);
        chk("rd_dat2",   64'(bus.req_dat_o), 64'hCAFE);
        nxt();
        bus.hbus_valid = 1'b0;
        bus.req_rrq    = '0;
        settle();
        chk("rd_rel_rrq",   64'(bus.hbus_rrq),  64'h0);
        chk("rd_rel_grant", 64'(bus.grant),     64'h4);
        nxt();
        bus.hbus_valid = 1'b1;
        settle();
        chk("rd_drain_valid", 64'(bus.req_valid), 64'h4);
        chk("rd_drain_rrq",   64'(bus.hbus_rrq),  64'h0);
        nxt();
        bus.hbus_valid = 1'b0;
        bus.hbus_busy  = 1'b0;
        settle();
        chk("rd_drain_hold", 64'(bus.grant), 64'h4);
        nxt();
        bus.req_wrq = 4'b1011;
        settle();
        chk("rd_idle_after", 64'(bus.grant), 64'h0);
        // ptr is now 3: of {0,1,3} requester 3 must win
        nxt();
        settle();
        chk("ptr3_grant", 64'(bus.grant),       64'h8);
        chk("ptr3_wrq",   64'(bus.hbus_wrq),    64'h1);
        chk("ptr3_adr",   64'(bus.hbus_adr_o),  64'hD0);
        chk("ptr3_dat",   64'(bus.hbus_dat_o),  64'h4444);
        chk("ptr3_mask",  64'(bus.hbus_mask_o), 64'h3);
        bus.hbus_ready = 1'b1;
        #1;
        chk("ptr3_ready", 64'(bus.req_ready), 64'h8);
        chk("ptr3_valid", 64'(bus.req_valid), 64'h0);
        nxt();
        bus.hbus_ready = 1'b0;
        bus.req_wrq    = '0;
        wait_idle();

        // ---------------- round robin, all four writing
        nxt();
        bus.req_wrq = 4'b1111;
        prev = '0;
        for (int n = 0; n < 5; n++) begin
            e = rr_ord[n];
            wait_grant(g);
            chk("rr_grant", 64'(g),               64'(1 << e));
            chk("rr_wrq",   64'(bus.hbus_wrq),    64'h1);
            chk("rr_adr",   64'(bus.hbus_adr_o),  64'(adr_tab[e]));
            chk("rr_dat",   64'(bus.hbus_dat_o),  64'(dat_tab[e]));
            if (n > 0) chk("rr_no_repeat", 64'(g != prev), 64'd1);
            prev = g;
            bus.hbus_ready = 1'b1;
            #1;
            chk("rr_ready1", 64'(bus.req_ready), 64'(1 << e));
            nxt();
            settle();
            chk("rr_ready2", 64'(bus.req_ready), 64'(1 << e));
            nxt();
            bus.hbus_ready = 1'b0;
            bus.req_wrq[e] = 1'b0;
            settle();
            chk("rr_drop_wrq", 64'(bus.hbus_wrq), 64'h0);
            wait_idle();
            bus.req_wrq[e] = 1'b1;
        end
        bus.req_wrq = '0;
        nxt();

        // ---------------- busy gating
        bus.hbus_busy = 1'b1;
        bus.req_rrq   = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            nxt();
            settle();
            chk("busy_no_grant", 64'(bus.grant), 64'h0);
        end
        nxt();
        bus.hbus_busy = 1'b0;
        settle();
        chk("busy_fall_grant", 64'(bus.grant), 64'h0);
        nxt();
        settle();
        chk("busy_grant", 64'(bus.grant),    64'h2);
        chk("busy_rrq",   64'(bus.hbus_rrq), 64'h1);
        nxt();
        bus.req_rrq = '0;
        wait_idle();

        // ---------------- both request bits set
        nxt();
        bus.req_rrq = 4'b0001;
        bus.req_wrq = 4'b0001;
        nxt();
        settle();
        chk("both_grant", 64'(bus.grant),    64'h1);
        chk("both_rrq",   64'(bus.hbus_rrq), 64'h1);
        chk("both_wrq",   64'(bus.hbus_wrq), 64'h0);
        nxt();
        bus.req_rrq = '0;
        bus.req_wrq = '0;
        wait_idle();

        // ---------------- watchdog, requester 3 never releases
        nxt();
        bus.req_rrq = 4'b1000;
        nxt();
        settle();
        chk("wd_grant",   64'(bus.grant),    64'h8);
        chk("wd_c0_err",  64'(bus.hold_err), 64'h0);
        bus.req_wrq = 4'b0010;
        for (int c = 1; c < 7; c++) begin
            nxt();
            settle();
            chk("wd_hold_grant", 64'(bus.grant),    64'h8);
            chk("wd_hold_rrq",   64'(bus.hbus_rrq), 64'h1);
            chk("wd_hold_err",   64'(bus.hold_err), 64'h0);
        end
        nxt();
        settle();
        chk("wd_fire_err", 64'(bus.hold_err), 64'h8);
        chk("wd_fire_rrq", 64'(bus.hbus_rrq), 64'h0);
        nxt();
        settle();
        chk("wd_drain_err",   64'(bus.hold_err), 64'h0);
        chk("wd_drain_grant", 64'(bus.grant),    64'h8);
        chk("wd_drain_rrq",   64'(bus.hbus_rrq), 64'h0);
        nxt();
        settle();
        chk("wd_idle_grant", 64'(bus.grant), 64'h0);
        nxt();
        settle();
        chk("wd_next_grant", 64'(bus.grant),    64'h2);
        chk("wd_next_wrq",   64'(bus.hbus_wrq), 64'h1);
        nxt();
        bus.req_rrq = '0;
        bus.req_wrq = '0;
        wait_idle();

        // ---------------- reset during a write from requester 2 (ptr = 2)
        nxt();
        bus.req_wrq = 4'b0100;
        nxt();
        settle();
        chk("rw_grant", 64'(bus.grant),    64'h4);
        chk("rw_wrq",   64'(bus.hbus_wrq), 64'h1);
        bus.hbus_ready = 1'b1;
        #1;
        chk("rw_ready", 64'(bus.req_ready), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_grant", 64'(bus.grant),     64'h0);
        chk("rw_rst_wrq",   64'(bus.hbus_wrq),  64'h0);
        chk("rw_rst_ready", 64'(bus.req_ready), 64'h0);
        bus.req_wrq = 4'b1010;
        nxt();
        settle();
        chk("rw_in_rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rw_in_rst_grant", 64'(bus.grant),     64'h0);
        nxt();
        rst_n = 1'b1;
        bus.hbus_ready = 1'b0;
        settle();
        chk("rw_post_idle", 64'(bus.grant), 64'h0);
        // ptr back at 0: of {1,3} requester 1 must win
        nxt();
        settle();
        chk("rw_ptr0_grant", 64'(bus.grant), 64'h2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
